// File: rtl/key_demux_if.sv
// Result-routing bus between the ALU side, the channel clients and key_demux.
// The master drives keys, results and channel handshakes. The slave is the
// demux, which returns per-channel results and status flags.
interface key_demux_if #(
    parameter int nchannels    = 2,
    parameter int key_size     = 4,
    parameter int operand_size = 32
);
    logic [key_size-1:0]               key_i;
    logic [operand_size-1:0]           O_i;
    logic [nchannels*key_size-1:0]     chan_key_i;
    logic [nchannels-1:0]              issue_i;
    logic [nchannels-1:0]              ack_i;
    logic [nchannels*operand_size-1:0] O_o;
    logic [nchannels-1:0]              valid_o;
    logic [nchannels-1:0]              busy_o;
    logic [nchannels-1:0]              err_o;
    logic [nchannels-1:0]              timeout_o;
    logic                              spurious_o;

    modport master (
        output key_i, O_i, chan_key_i, issue_i, ack_i,
        input  O_o, valid_o, busy_o, err_o, timeout_o, spurious_o
    );

    modport slave (
        input  key_i, O_i, chan_key_i, issue_i, ack_i,
        output O_o, valid_o, busy_o, err_o, timeout_o, spurious_o
    );
endinterface

// File: rtl/key_demux.sv
// Routes keyed ALU results back to the client channel that issued the request.
// Each channel runs its own FSM and has a bounded wait counter.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no outstanding request
//   PENDING | request accepted by the ALU; waiting for its key
//   FULL    | result captured and held until the consumer acks
module key_demux #(
    parameter int nchannels    = 2,
    parameter int key_size     = 4,
    parameter int operand_size = 32,
    parameter int timeout      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    key_demux_if.slave  bus
);
    localparam int cnt_w = $clog2(timeout) + 1;
    localparam logic [cnt_w-1:0] cnt_max  = '1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

    typedef enum logic [1:0] {IDLE, PENDING, FULL} state_t;

    state_t                  state_q [nchannels];
    state_t                  state_d [nchannels];
    logic [cnt_w-1:0]        cnt_q   [nchannels];
    logic [cnt_w-1:0]        cnt_d   [nchannels];
    logic [operand_size-1:0] data_q  [nchannels];
    logic [operand_size-1:0] data_d  [nchannels];
    logic [nchannels-1:0]    err_q, err_d;
    logic [nchannels-1:0]    tmo_q, tmo_d;
    logic                    spur_q, spur_d;

    logic [nchannels-1:0]    grant;
    logic [nchannels-1:0]    overrun;
    logic                    pend_taken;

    // Key match: the lowest-index PENDING channel owning the key captures.
    // A FULL channel that is not being acked reports an overrun.
    always_comb begin
        grant      = '0;
        overrun    = '0;
        pend_taken = 1'b0;
        for (int n = 0; n < nchannels; n++) begin
            if (bus.key_i != '0 && bus.key_i == bus.chan_key_i[n*key_size +: key_size]) begin
                if (state_q[n] == PENDING && !pend_taken) begin
                    grant[n]   = 1'b1;
                    pend_taken = 1'b1;
                end
                if (state_q[n] == FULL && !bus.ack_i[n]) begin
                    overrun[n] = 1'b1;
                end
            end
        end
    end

    // Per-channel next state, wait counter, capture data and sticky flags.
    always_comb begin
        err_d  = err_q;
        tmo_d  = tmo_q;
        spur_d = spur_q | ((bus.key_i != '0) && !pend_taken && (overrun == '0));
        for (int n = 0; n < nchannels; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            data_d[n]  = data_q[n];
            case (state_q[n])
                IDLE: begin
                    if (bus.issue_i[n]) begin
                        state_d[n] = PENDING;
                        cnt_d[n]   = '0;
                    end
                end
                PENDING: begin
                    if (bus.issue_i[n]) err_d[n] = 1'b1;
                    if (cnt_q[n] != cnt_max) cnt_d[n] = cnt_q[n] + 1'b1;
                    // A match on the expiry cycle still counts as delivered.
                    if (grant[n]) begin
                        data_d[n]  = bus.O_i;
                        state_d[n] = FULL;
                    end else if (cnt_q[n] == cnt_last) begin
                        state_d[n] = IDLE;
                        tmo_d[n]   = 1'b1;
                    end
                end
                FULL: begin
                    if (bus.ack_i[n]) begin
                        if (bus.issue_i[n]) begin
                            state_d[n] = PENDING;
                            cnt_d[n]   = '0;
                        end else begin
                            state_d[n] = IDLE;
                        end
                    end else if (bus.issue_i[n] || overrun[n]) begin
                        err_d[n] = 1'b1;
                    end
                end
                default: state_d[n] = IDLE;
            endcase
        end
    end

    // State register: async reset, then clear, then enable-gated update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < nchannels; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
                data_q[n]  <= '0;
            end
            err_q  <= '0;
            tmo_q  <= '0;
            spur_q <= 1'b0;
        end else if (clr) begin
            for (int n = 0; n < nchannels; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
                data_q[n]  <= '0;
            end
            err_q  <= '0;
            tmo_q  <= '0;
            spur_q <= 1'b0;
        end else if (en) begin
            for (int n = 0; n < nchannels; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                data_q[n]  <= data_d[n];
            end
            err_q  <= err_d;
            tmo_q  <= tmo_d;
            spur_q <= spur_d;
        end
    end

    // Status and result outputs decoded straight from registered state.
    for (genvar g = 0; g < nchannels; g++) begin : g_out
        assign bus.O_o[g*operand_size +: operand_size] = data_q[g];
        assign bus.valid_o[g] = (state_q[g] == FULL);
        assign bus.busy_o[g]  = (state_q[g] == PENDING);
    end

    assign bus.err_o      = err_q;
    assign bus.timeout_o  = tmo_q;
    assign bus.spurious_o = spur_q;
endmodule

// File: tb/tb_key_demux.sv
// Directed bench for key_demux with two channels and an 8-cycle wait limit.
module tb_key_demux;
    logic clk;
    logic rst;
    logic clr;
    logic en;
    int   n_checks;
    int   n_pass;

    key_demux_if #(.nchannels(2), .key_size(4), .operand_size(32)) bus ();

    key_demux #(
        .nchannels(2), .key_size(4), .operand_size(32), .timeout(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .en (en),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.key_i   = '0;
        bus.O_i     = '0;
        bus.issue_i = '0;
        bus.ack_i   = '0;
        clr         = 1'b0;
    endtask

    task automatic flags_zero(input string tag);
        chk(tag, {bus.err_o, bus.timeout_o, bus.spurious_o}, 64'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        en             = 1'b1;
        bus.chan_key_i = {4'd4, 4'd5};
        quiet();
        tick();
        tick();
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_O", bus.O_o, 0);
        flags_zero("rst_flags");
        rst = 1'b0;

        // basic capture on ch0 (key 5)
        bus.issue_i = 2'b01; tick(); quiet();
        chk("cap_busy", bus.busy_o, 2'b01);
        tick();
        chk("cap_wait_valid", bus.valid_o, 0);
        bus.key_i = 4'd5; bus.O_i = 32'hff9b8800; tick(); quiet();
        chk("cap_valid", bus.valid_o, 2'b01);
        chk("cap_busy_low", bus.busy_o, 0);
        chk("cap_O", bus.O_o, 64'h0000_0000_ff9b_8800);
        bus.ack_i = 2'b01; tick(); quiet();
        chk("cap_ack", bus.valid_o, 0);
        chk("cap_O_hold", bus.O_o, 64'h0000_0000_ff9b_8800);
        chk("cap_spur", bus.spurious_o, 0);

        // overrun on ch1 (key 4)
        bus.issue_i = 2'b10; tick(); quiet();
        bus.key_i = 4'd4; bus.O_i = 32'h09a96480; tick(); quiet();
        chk("ovr_valid", bus.valid_o, 2'b10);
        bus.key_i = 4'd4; bus.O_i = 32'h12345678; tick(); quiet();
        chk("ovr_O", bus.O_o[63:32], 32'h09a96480);
        chk("ovr_err", bus.err_o, 2'b10);
        chk("ovr_not_spur", bus.spurious_o, 0);
        bus.ack_i = 2'b10; tick(); quiet();
        chk("ovr_err_sticky", bus.err_o, 2'b10);
        clr = 1'b1; tick(); quiet();
        flags_zero("clr1_flags");
        chk("clr1_O", bus.O_o, 0);

        // timeout expiry after exactly 8 PENDING cycles
        bus.issue_i = 2'b01; tick(); quiet();
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_busy7", bus.busy_o, 2'b01);
        chk("tmo_flag7", bus.timeout_o, 0);
        tick();
        chk("tmo_busy8", bus.busy_o, 0);
        chk("tmo_flag8", bus.timeout_o, 2'b01);
        clr = 1'b1; tick(); quiet();

        // match on the expiry cycle wins
        bus.issue_i = 2'b01; tick(); quiet();
        for (int i = 0; i < 7; i++) tick();
        bus.key_i = 4'd5; bus.O_i = 32'ha5a5a5a5; tick(); quiet();
        chk("late_valid", bus.valid_o, 2'b01);
        chk("late_tmo", bus.timeout_o, 0);
        chk("late_O", bus.O_o[31:0], 32'ha5a5a5a5);

        // back-to-back ack + issue
        bus.ack_i = 2'b01; bus.issue_i = 2'b01; tick(); quiet();
        chk("b2b_busy", bus.busy_o, 2'b01);
        chk("b2b_valid", bus.valid_o, 0);
        chk("b2b_err", bus.err_o, 0);
        bus.key_i = 4'd5; bus.O_i = 32'h11112222; tick(); quiet();
        chk("b2b_O", bus.O_o[31:0], 32'h11112222);
        bus.ack_i = 2'b01; tick(); quiet();

        // enable low drops the issue
        en = 1'b0; bus.issue_i = 2'b01; tick(); quiet(); en = 1'b1;
        chk("en_hold", bus.busy_o, 0);

        // spurious key with everything idle
        bus.key_i = 4'd7; tick(); quiet();
        chk("spur_set", bus.spurious_o, 1);
        clr = 1'b1; tick(); quiet();

        // duplicate keys: only ch0 captures
        bus.chan_key_i = {4'd5, 4'd5};
        bus.issue_i = 2'b11; tick(); quiet();
        chk("dup_busy", bus.busy_o, 2'b11);
        bus.key_i = 4'd5; bus.O_i = 32'hcafef00d; tick(); quiet();
        chk("dup_valid", bus.valid_o, 2'b01);
        chk("dup_busy1", bus.busy_o, 2'b10);
        chk("dup_O", bus.O_o, 64'h0000_0000_cafe_f00d);
        chk("dup_spur", bus.spurious_o, 0);
        bus.ack_i = 2'b01; tick(); quiet();

        // async reset while ch1 is PENDING
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_O", bus.O_o, 0);
        tick();
        rst = 1'b0;
        bus.key_i = 4'd5; bus.O_i = 32'hdeadbeef; tick(); quiet();
        chk("arst_late_spur", bus.spurious_o, 1);
        chk("arst_late_valid", bus.valid_o, 0);
        clr = 1'b1; tick(); quiet();
        flags_zero("clr_end_flags");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_demux.md
KEY_DEMUX -- requirements
Module: key_demux

Interface
REQ-001 Parameter nchannels, default 2: number of client channels.
REQ-002 Parameter key_size, default 4: width of one result key.
REQ-003 Parameter operand_size, default 32: width of one result word.
REQ-004 Parameter timeout, default 64: maximum cycles a channel waits for its result.
REQ-005 clk  in  1: single clock; all state updates on posedge clk.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 clr  in  1: synchronous clear.
REQ-008 en  in  1: enable; when low, all state holds.
REQ-009 key_i  in  key_size: key returned by the ALU; 0 means no result this cycle.
REQ-010 O_i  in  operand_size: ALU result word, qualified by key_i != 0.
REQ-011 chan_key_i  in  nchannels*key_size: key owned by each channel; channel n uses slice n.
REQ-012 issue_i  in  nchannels: one-cycle pulse meaning channel n's request was accepted by the ALU.
REQ-013 ack_i  in  nchannels: consumer of channel n has taken the result.
REQ-014 O_o  out  nchannels*operand_size: registered result per channel.
REQ-015 valid_o  out  nchannels: channel n holds an unconsumed result.
REQ-016 busy_o  out  nchannels: channel n is waiting for a result.
REQ-017 err_o  out  nchannels: sticky flag for overrun or illegal issue.
REQ-018 timeout_o  out  nchannels: sticky flag; the wait limit expired.
REQ-019 spurious_o  out  1: sticky flag; a nonzero key_i matched no waiting channel.

Function
REQ-020 Each channel SHALL run an independent FSM with three states.
- IDLE: busy_o=0, valid_o=0.
- PENDING: busy_o=1, valid_o=0.
- FULL: busy_o=0, valid_o=1.
REQ-021 IDLE with issue_i[n] SHALL go to PENDING and clear the channel wait counter.
REQ-022 PENDING with key_i equal to chan_key_i[n] (key_i != 0) SHALL capture O_i into O_o[n] and go to FULL; valid_o SHALL rise on the cycle after the match.
REQ-023 In PENDING, the wait counter SHALL increment every enabled cycle.
- With no match on the timeout-th PENDING cycle, the channel SHALL return to IDLE and set timeout_o[n].
- If a match and expiry fall on the same cycle, the match SHALL win.
REQ-024 FULL with ack_i[n] SHALL go to IDLE.
- FULL with ack_i[n] and issue_i[n] in the same cycle SHALL go directly to PENDING.
REQ-025 FULL with a key match and no ack_i[n] SHALL keep O_o[n] unchanged and set err_o[n] (overrun).
REQ-026 issue_i[n] in PENDING, or in FULL without ack_i[n], SHALL be ignored and SHALL set err_o[n].
REQ-027 ack_i[n] outside FULL SHALL be ignored.
REQ-028 If several PENDING channels share the matching key, only the lowest-index channel SHALL capture; the others SHALL stay unaffected.
REQ-029 A nonzero key_i that matches no PENDING channel, and is not an overrun, SHALL set spurious_o.
REQ-030 O_o[n] SHALL change only on capture, reset or clr.
REQ-031 The wait counter SHALL be clog2(timeout)+1 bits wide and SHALL saturate rather than wrap.
REQ-032 clr SHALL have priority over all other inputs and SHALL act regardless of en.
- All FSMs to IDLE.
- Counters, O_o and all sticky flags to 0.
REQ-033 en low SHALL freeze FSMs, counters, O_o and flags; inputs in that cycle SHALL be lost.

Reset
REQ-034 rst high SHALL immediately force, without waiting for clk:
- all FSMs to IDLE;
- O_o, valid_o, busy_o, err_o, timeout_o and spurious_o to 0.
REQ-035 rst asserted while a channel is PENDING or FULL SHALL discard that transaction; a result arriving after reset release SHALL count as spurious.

Verification
REQ-036 The bench SHALL cover the following directed scenarios.
- Basic capture: chan keys {4,5}; issue ch0 (key 5); key_i=5, O_i=32'hff9b8800 two cycles later -> O_o[0]=ff9b8800, valid_o[0]=1 the next cycle; ack -> valid_o[0]=0.
- Overrun: ch1 FULL with 32'h09a96480, no ack; key_i=4, O_i=32'h12345678 -> O_o[1] stays 09a96480, err_o[1]=1.
- Timeout: timeout=8; issue ch0, no result -> busy_o[0] falls and timeout_o[0]=1 after exactly 8 cycles; result on cycle 8 -> capture, no timeout.
- Back-to-back: ack and issue on ch0 in the same cycle -> busy_o[0]=1 next cycle, no err_o.
- Spurious and duplicate: key_i=7 with all channels idle -> spurious_o=1; both channels keyed 5 and PENDING, key_i=5 -> only ch0 captures.
- Async reset: assert rst mid-PENDING between clock edges -> busy_o=0 before the next edge; clr pulse -> all flags 0.
